// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs big-endian 32-bit words
// and writes them at consecutive word addresses while holding the CPU stalled.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic [5:0]        word_count_o
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        byte_idx;
    logic [31:0]       word_buf;
    logic [31:0]       merged;
    logic              last_seen;
    logic [5:0]        word_cnt;
    logic [ADDR_W-1:0] waddr_r;
    logic [31:0]       wdata_r;
    logic              accept;
    logic              word_end;
    logic              start_ok;
    logic              mem_full;

    assign accept   = (state == RECV) && in_valid_i;
    assign word_end = accept && ((byte_idx == 2'd3) || in_last_i);
    assign start_ok = start_i && ((state == IDLE) || (state == DONE));
    assign mem_full = (word_cnt + 6'd1) == 6'(DEPTH);

    // First byte of a word is the MSB; unfilled low bytes stay zero.
    always_comb begin
        merged = word_buf;
        case (byte_idx)
            2'd0:    merged[31:24] = in_data_i;
            2'd1:    merged[23:16] = in_data_i;
            2'd2:    merged[15:8]  = in_data_i;
            default: merged[7:0]   = in_data_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RECV;
            RECV:    if (word_end) state_nxt = WRITE;
            WRITE:   state_nxt = (last_seen || mem_full) ? DONE : RECV;
            DONE:    if (start_i) state_nxt = RECV;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = (state == RECV);
        we_o       = (state == WRITE);
        cpu_hold_o = (state == RECV) || (state == WRITE);
        done_o     = (state == DONE);
    end

    // Address/data are captured when the word completes so they are valid
    // throughout WRITE and hold their last value afterwards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            byte_idx  <= 2'd0;
            word_buf  <= 32'd0;
            last_seen <= 1'b0;
            word_cnt  <= 6'd0;
            waddr_r   <= '0;
            wdata_r   <= 32'd0;
        end else if (start_ok) begin
            byte_idx  <= 2'd0;
            word_buf  <= 32'd0;
            last_seen <= 1'b0;
            word_cnt  <= 6'd0;
        end else if (word_end) begin
            wdata_r   <= merged;
            waddr_r   <= ADDR_W'({word_cnt, 2'b00});
            last_seen <= in_last_i;
            byte_idx  <= 2'd0;
            word_buf  <= 32'd0;
        end else if (accept) begin
            word_buf  <= merged;
            byte_idx  <= byte_idx + 2'd1;
        end else if (state == WRITE) begin
            word_cnt  <= word_cnt + 6'd1;
        end
    end

    assign waddr_o      = waddr_r;
    assign wdata_o      = wdata_r;
    assign word_count_o = word_cnt;

endmodule
